// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_IF_BUSY = 2'b01,
        ST_DM_BUSY = 2'b10,
        ST_DRAIN   = 2'b11
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Single-port memory bus: arbiter is master, memory is slave.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = mem_bus_arbiter_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_bus_arbiter_pkg::DATA_W_DEF
);
    import mem_bus_arbiter_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [SEL_W-1:0]  bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
// Counts busy cycles without bus_ack; expired_c flags the last allowed cycle.
module bus_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiring on TIMEOUT-1 keeps bus_req high for exactly TIMEOUT cycles.
    assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch and data memory.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [SEL_W-1:0]  dm_sel,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,

    input  logic              flush,

    mem_bus_arbiter_if.master bus,

    output logic              stall_req,
    output logic              timeout_err
);

    arb_state_t        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_ready_q, dm_ready_d;
    logic              timeout_err_q, timeout_err_d;

    logic              cnt_clr, cnt_en, expired_c;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_sel_d     = bus_sel_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        if_rdata_d    = if_rdata_q;
        if_ready_d    = 1'b0;
        dm_rdata_d    = dm_rdata_q;
        dm_ready_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Hold off while a stage may still be dropping its served request.
                if (!(if_ready_q || dm_ready_q || flush)) begin
                    if (dm_req) begin
                        state_d     = ST_DM_BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = dm_we;
                        bus_sel_d   = dm_sel;
                        bus_addr_d  = dm_addr;
                        bus_wdata_d = dm_wdata;
                        cnt_clr     = 1'b1;
                    end else if (if_req) begin
                        state_d     = ST_IF_BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_sel_d   = {SEL_W{1'b1}};
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        cnt_clr     = 1'b1;
                    end
                end
            end

            ST_IF_BUSY: begin
                if (bus.bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    cnt_clr   = 1'b1;
                    if (!flush) begin
                        if_rdata_d = bus.bus_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (expired_c) begin
                    state_d       = ST_IDLE;
                    bus_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_clr       = 1'b1;
                    if (!flush) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DM_BUSY: begin
                if (bus.bus_ack) begin
                    state_d    = ST_IDLE;
                    bus_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    cnt_clr    = 1'b1;
                    if (!bus_we_q) begin
                        dm_rdata_d = bus.bus_rdata;
                    end
                end else if (expired_c) begin
                    state_d       = ST_IDLE;
                    bus_req_d     = 1'b0;
                    dm_ready_d    = 1'b1;
                    dm_rdata_d    = '0;
                    timeout_err_d = 1'b1;
                    cnt_clr       = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Flushed fetch: finish the bus cycle, discard the data.
                if (bus.bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    cnt_clr   = 1'b1;
                end else if (expired_c) begin
                    state_d       = ST_IDLE;
                    bus_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_clr       = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_sel_q     <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            if_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            dm_rdata_q    <= '0;
            dm_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_sel_q     <= bus_sel_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            if_rdata_q    <= if_rdata_d;
            if_ready_q    <= if_ready_d;
            dm_rdata_q    <= dm_rdata_d;
            dm_ready_q    <= dm_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign dm_rdata    = dm_rdata_q;
    assign dm_ready    = dm_ready_q;
    assign timeout_err = timeout_err_q;

    // Pipeline holds while any stage is waiting on the bus.
    assign stall_req = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (IF) and the data-memory port (MEM stage) of the 5-stage MIPS pipeline.
- Sequences each transaction with a registered req/ack handshake and returns read data to the winning requester.
- Raises a stall request to the pipeline controller while any requester is waiting, so the pipeline registers up to mem_wb hold.
- Handles exception flush of an in-flight fetch and a bus-timeout error.

Parameters:
- TIMEOUT, 255: maximum cycles a bus transaction may wait for bus_ack; counter width 8 bits.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store.
- dm_sel  in  4  byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_ready  out  1  one-cycle pulse: data access done.
- flush  in  1  exception/branch flush from pipeline controller.
- bus_req  out  1  memory request; held until bus_ack.
- bus_we  out  1  write enable.
- bus_sel  out  4  byte enables.
- bus_addr  out  ADDR_W  address.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion from memory.
- stall_req  out  1  to pipeline controller.
- timeout_err  out  1  sticky bus-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including bus_req, if_ready, dm_ready, if_rdata, dm_rdata and timeout_err. Timeout counter 0. A reset mid-transaction drops bus_req immediately; any later bus_ack is ignored while in IDLE.
- States:
  - IDLE.
  - IF_BUSY.
  - DM_BUSY.
  - DRAIN: flushed fetch awaiting its ack.
- IDLE grant:
  - No grant in a cycle where if_ready, dm_ready or flush is 1. This prevents re-granting a request the stage has not yet dropped.
  - Otherwise dm_req wins over if_req (the older instruction wins; this avoids deadlock).
  - Grant latches the address/we/sel/wdata into bus_* registers, sets bus_req=1 at the next edge and moves to *_BUSY. An IF grant drives bus_we=0 and bus_sel=4'hF.
- BUSY: bus_* outputs are stable until bus_ack. The counter increments each cycle without ack.
- Ack in IF_BUSY/DM_BUSY:
  - Next edge: bus_req=0; {if|dm}_rdata <= bus_rdata (stores: dm_rdata unchanged); {if|dm}_ready=1 for exactly one cycle.
  - Return to IDLE and clear the counter.
  - Minimum latency from req to ready is 2 cycles with zero-wait memory (grant edge, ack cycle, ready edge).
- Flush:
  - IF_BUSY: go to DRAIN. bus_req stays asserted until ack, the data is discarded, no if_ready pulse, then IDLE.
  - DM_BUSY: ignored, because the access is already committed by the controller.
  - IDLE: blocks grants that cycle.
  - DRAIN: no effect.
- Flush and bus_ack in the same cycle in IF_BUSY: the ack completes but if_ready is suppressed; go to IDLE.
- Timeout: counter reaches TIMEOUT in any busy state, then:
  - bus_req=0 and timeout_err=1; it stays 1 until reset.
  - The requester gets its ready pulse with rdata=0 (no pulse if DRAIN).
  - Return to IDLE.
- stall_req (combinational) = (if_req & ~if_ready) | (dm_req & ~dm_ready).
- Addresses are not checked; alignment faults are handled upstream.

Decomposition:
- The shared defines include holds: state encodings (IDLE=2'b00, IF_BUSY=2'b01, DM_BUSY=2'b10, DRAIN=2'b11), bus width macros (reuse InstAddrBus/RegBus) and the TIMEOUT default.
- One natural sub-module: bus_timeout_cnt (clear/enable/expired). The rest stays flat.

Test Plan:
- if_req=1, addr 0x00000100, memory acks 1 cycle after bus_req with 0x24020005 -> bus_addr=0x100, bus_we=0; if_ready pulses once; if_rdata=0x24020005; stall_req drops with if_ready.
- if_req and dm_req (load 0x80000010) asserted in the same cycle -> DM served first; dm_ready, then if_ready granted no earlier than 1 cycle after the dm_ready pulse; no duplicate bus transaction while dm_req is still high during its ready cycle.
- Store dm_we=1, sel=4'b0011, wdata 0xDEADBEEF, ack after 3 wait cycles -> bus_* stable across all 4 request cycles; dm_ready pulse; dm_rdata unchanged.
- Fetch in flight, flush pulsed for 1 cycle, ack 2 cycles later -> no if_ready; bus_req held until ack; next grant accepted after return to IDLE.
- TIMEOUT=4, memory never acks -> bus_req drops after 4 cycles; timeout_err=1 and sticky; requester ready pulse with rdata=0.
- rst pulled low while in DM_BUSY -> bus_req and all outputs 0 asynchronously; a stray bus_ack after release causes no ready pulse.
